// File: rtl/psum_pkg.sv
// Shared types for the partial-sum buffer: FSM state encoding, default word width,
// and the address-width helper.
package psum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int PSUM_DW = 25;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/psum_buf_ram.sv
// Simple dual-port storage for psum words: synchronous write, synchronous one-cycle read.
// The read register only updates on re, so it holds its word between reads.
module psum_buf_ram
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DW,
    parameter int DEPTH      = 64,
    parameter int AW         = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/psum_buffer.sv
// Partial-sum feedback buffer: replays stored psums to the adder on each input-channel pass
// and drains final sums after the last pass. Define PSUM_BUF_RELU_EN to clamp drained words at 0.
module psum_buffer
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DW,
    parameter int DEPTH      = 64,
    parameter int AW         = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW:0]           cfg_len,
    input  logic [7:0]            cfg_passes,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  drain_valid,
    input  logic                  drain_ready,
    output logic [DATA_WIDTH-1:0] drain_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_ovf,
    output logic                  err_unf
);

    state_t                state;
    logic [AW:0]           len;
    logic [7:0]            passes;
    logic [7:0]            pass;
    logic [AW:0]           count;
    logic [AW:0]           wr_cnt;
    logic [AW:0]           rd_cnt;
    logic [AW:0]           issued;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  fifo_zero;
    logic                  q_valid;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] drain_word;

    logic          in_accum, in_drain, full, empty;
    logic          pop, push, issue, load_out, out_fire, ram_re;
    logic [AW:0]   last_idx;
    logic [AW-1:0] rd_ptr_nxt, wr_ptr_nxt;

    assign in_accum   = (state == ST_ACCUM);
    assign in_drain   = (state == ST_DRAIN);
    assign full       = (count == len);
    assign empty      = (count == '0);
    assign last_idx   = len - (AW+1)'(1);
    // Pointers wrap at the tile length, not at DEPTH.
    assign rd_ptr_nxt = ({1'b0, rd_ptr} == last_idx) ? '0 : rd_ptr + AW'(1);
    assign wr_ptr_nxt = ({1'b0, wr_ptr} == last_idx) ? '0 : wr_ptr + AW'(1);

    assign pop      = in_accum && rd_req && (pass != 8'd0) && !empty;
    assign push     = in_accum && wr_valid && !full;
    assign out_fire = drain_valid && drain_ready;
    // RAM read register acts as a prefetch stage ahead of the output register.
    assign load_out = in_drain && q_valid && (!drain_valid || drain_ready);
    assign issue    = in_drain && (issued != len) && (!q_valid || load_out);
    assign ram_re   = pop || issue;

    assign fifo_data = fifo_zero ? '0 : ram_q;

`ifdef PSUM_BUF_RELU_EN
    assign drain_word = ram_q[DATA_WIDTH-1] ? '0 : ram_q;
`else
    assign drain_word = ram_q;
`endif

    psum_buf_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(wr_data),
        .re   (ram_re),
        .raddr(rd_ptr),
        .rdata(ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            len         <= '0;
            passes      <= '0;
            pass        <= '0;
            count       <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            issued      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_zero   <= 1'b1;
            q_valid     <= 1'b0;
            drain_valid <= 1'b0;
            drain_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_ovf     <= 1'b0;
            err_unf     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ACCUM;
                        busy      <= 1'b1;
                        len       <= cfg_len;
                        passes    <= cfg_passes;
                        pass      <= '0;
                        count     <= '0;
                        wr_cnt    <= '0;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        fifo_zero <= 1'b1;
                        q_valid   <= 1'b0;
                        err_ovf   <= 1'b0;
                        err_unf   <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (rd_req) begin
                        if (pass == 8'd0) begin
                            fifo_zero <= 1'b1;
                        end else if (empty) begin
                            fifo_zero <= 1'b1;
                            err_unf   <= 1'b1;
                        end else begin
                            fifo_zero <= 1'b0;
                            rd_ptr    <= rd_ptr_nxt;
                        end
                    end
                    if (wr_valid) begin
                        if (full)
                            err_ovf <= 1'b1;
                        else
                            wr_ptr <= wr_ptr_nxt;
                        // Dropped words still count so pass sequencing stays aligned with the adder.
                        if (wr_cnt == last_idx) begin
                            wr_cnt <= '0;
                            if (pass == passes - 8'd1) begin
                                state   <= ST_DRAIN;
                                issued  <= '0;
                                rd_cnt  <= '0;
                                q_valid <= 1'b0;
                            end else begin
                                pass <= pass + 8'd1;
                            end
                        end else begin
                            wr_cnt <= wr_cnt + (AW+1)'(1);
                        end
                    end
                    if (push && !pop)
                        count <= count + (AW+1)'(1);
                    else if (pop && !push)
                        count <= count - (AW+1)'(1);
                end
                ST_DRAIN: begin
                    if (issue) begin
                        rd_ptr <= rd_ptr_nxt;
                        issued <= issued + (AW+1)'(1);
                        if (!empty)
                            count <= count - (AW+1)'(1);
                    end
                    q_valid <= issue || (q_valid && !load_out);
                    if (load_out) begin
                        drain_valid <= 1'b1;
                        drain_data  <= drain_word;
                    end else if (out_fire) begin
                        drain_valid <= 1'b0;
                    end
                    if (out_fire) begin
                        if (rd_cnt == last_idx) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            rd_cnt <= rd_cnt + (AW+1)'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
